// File: rtl/bmu_pkg.sv
// bmu_pkg: shared types and widths for the BMU arbiter slice.
package bmu_pkg;
    localparam int AP_W       = 42;
    localparam int DEF_DATA_W = 32;

    // Decoded ALU/BMU op packet; one-hot op flags followed by extended control bits.
    typedef struct packed {
        logic                land;
        logic                lor;
        logic                lxor;
        logic                sll;
        logic                srl;
        logic                sra;
        logic                ror;
        logic                rol;
        logic                add;
        logic                sub;
        logic [AP_W-11:0]    ext;
    } rtl_alu_pkt_t;
endpackage

// File: rtl/bmu_arbiter_if.sv
// bmu_arbiter_if: requester request/response ports plus the BMU drive/return bus.
interface bmu_arbiter_if
    import bmu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = DEF_DATA_W
);
    logic [NUM_REQ-1:0]             reqValid, reqReady, reqCsrRen;
    rtl_alu_pkt_t [NUM_REQ-1:0]     reqAp;
    logic [NUM_REQ-1:0][DATA_W-1:0] reqA, reqB, reqCsrRdata;
    logic [NUM_REQ-1:0]             rspValid, rspReady, rspError;
    logic [NUM_REQ-1:0][DATA_W-1:0] rspResult;
    logic                           bmuValidIn, bmuCsrRenIn, bmuError;
    rtl_alu_pkt_t                   bmuAp;
    logic [DATA_W-1:0]              bmuAIn, bmuBIn, bmuCsrRdataIn, bmuResultFf;

    modport master (
        output reqValid, reqAp, reqA, reqB, reqCsrRen, reqCsrRdata, rspReady, bmuResultFf, bmuError,
        input  reqReady, rspValid, rspResult, rspError, bmuValidIn, bmuAp, bmuAIn, bmuBIn, bmuCsrRenIn, bmuCsrRdataIn
    );
    modport slave (
        input  reqValid, reqAp, reqA, reqB, reqCsrRen, reqCsrRdata, rspReady, bmuResultFf, bmuError,
        output reqReady, rspValid, rspResult, rspError, bmuValidIn, bmuAp, bmuAIn, bmuBIn, bmuCsrRenIn, bmuCsrRdataIn
    );
endinterface

// File: rtl/bmu_rr_arbiter.sv
// bmu_rr_arbiter: round-robin one-hot grant starting at the pointer; pointer moves past each winner.
module bmu_rr_arbiter #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_eligible,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_grant_idx,
    output logic         o_grant_vld
);
    logic [W-1:0] r_ptr, w_hi, w_lo;
    logic         w_hi_vld;

    // Descending scan leaves the lowest eligible index at/after the pointer in w_hi, overall lowest in w_lo.
    always_comb begin
        w_hi        = '0;
        w_lo        = '0;
        w_hi_vld    = 1'b0;
        o_grant_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_eligible[W'(i)] && W'(i) >= r_ptr) begin
                w_hi     = W'(i);
                w_hi_vld = 1'b1;
            end
            if (i_eligible[W'(i)]) begin
                w_lo        = W'(i);
                o_grant_vld = 1'b1;
            end
        end
        o_grant_idx = w_hi_vld ? w_hi : w_lo;
        o_grant     = o_grant_vld ? N'(1) << o_grant_idx : '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= '0;
        else if (o_grant_vld)
            r_ptr <= (o_grant_idx == W'(N - 1)) ? '0 : o_grant_idx + 1'b1;
    end
endmodule

// File: rtl/bmu_arbiter.sv
// bmu_arbiter: shares one BMU across NUM_REQ requesters with round-robin issue,
// tag tracking across the BMU latency and a single response slot per requester.
module bmu_arbiter
    import bmu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int BMU_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    bmu_arbiter_if.slave bus
);
    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [TAG_W-1:0] tag_t;

    logic [NUM_REQ-1:0] w_credit, w_eligible, w_grant, w_ret;
    logic               w_grant_vld;
    tag_t               w_grant_idx;
    logic [NUM_REQ-1:0] r_in_flight, r_rsp_valid;
    logic [BMU_LAT:0]   r_pipe_vld;
    tag_t [BMU_LAT:0]   r_pipe_tag;
    logic               r_bmu_vld, r_bmu_csr_ren;
    rtl_alu_pkt_t       r_bmu_ap;
    logic [DATA_W-1:0]  r_bmu_a, r_bmu_b, r_bmu_csr_rdata;

    // One outstanding op per requester, the response slot included; a draining slot frees credit at once.
    assign w_credit     = ~r_in_flight & (~r_rsp_valid | bus.rspReady);
    assign w_eligible   = rst ? '0 : bus.reqValid & w_credit;
    assign bus.reqReady = w_grant;

    bmu_rr_arbiter #(.N(NUM_REQ), .W(TAG_W)) u_rr (
        .clk         (clk),
        .rst         (rst),
        .i_eligible  (w_eligible),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_vld (w_grant_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bmu_vld       <= 1'b0;
            r_bmu_ap        <= '0;
            r_bmu_a         <= '0;
            r_bmu_b         <= '0;
            r_bmu_csr_ren   <= 1'b0;
            r_bmu_csr_rdata <= '0;
        end else begin
            r_bmu_vld <= w_grant_vld;
            r_bmu_ap  <= w_grant_vld ? bus.reqAp[w_grant_idx] : '0;
            if (w_grant_vld) begin
                r_bmu_a         <= bus.reqA[w_grant_idx];
                r_bmu_b         <= bus.reqB[w_grant_idx];
                r_bmu_csr_ren   <= bus.reqCsrRen[w_grant_idx];
                r_bmu_csr_rdata <= bus.reqCsrRdata[w_grant_idx];
            end
        end
    end

    assign bus.bmuValidIn    = r_bmu_vld;
    assign bus.bmuAp         = r_bmu_ap;
    assign bus.bmuAIn        = r_bmu_a;
    assign bus.bmuBIn        = r_bmu_b;
    assign bus.bmuCsrRenIn   = r_bmu_csr_ren;
    assign bus.bmuCsrRdataIn = r_bmu_csr_rdata;

    // Tag pipe exit lines up with the cycle bmuResultFf holds that op's result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_flight <= '0;
            r_rsp_valid <= '0;
            r_pipe_vld  <= '0;
            r_pipe_tag  <= '0;
        end else begin
            r_in_flight <= w_grant | (r_in_flight & ~w_ret);
            r_rsp_valid <= w_ret | (r_rsp_valid & ~bus.rspReady);
            r_pipe_vld  <= {r_pipe_vld[BMU_LAT-1:0], w_grant_vld};
            r_pipe_tag  <= {r_pipe_tag[BMU_LAT-1:0], w_grant_idx};
        end
    end

    assign bus.rspValid = r_rsp_valid;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
        logic [DATA_W-1:0] r_result;
        logic              r_error;
        assign w_ret[g] = r_pipe_vld[BMU_LAT] && r_pipe_tag[BMU_LAT] == tag_t'(g);
        always_ff @(posedge clk) begin
            if (rst) begin
                r_result <= '0;
                r_error  <= 1'b0;
            end else if (w_ret[g]) begin
                r_result <= bus.bmuResultFf;
                r_error  <= bus.bmuError;
            end
        end
        assign bus.rspResult[g] = r_result;
        assign bus.rspError[g]  = r_error;
    end
endmodule

// File: tb/tb_bmu_arbiter.sv
// tb_bmu_arbiter: directed checks of arbitration, credit, backpressure, error capture and reset.
module tb_bmu_arbiter;
    import bmu_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         force_err;
    logic [31:0]  m_res;
    logic         m_err;
    rtl_alu_pkt_t ap_add, ap_sra;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    bmu_arbiter_if #(.NUM_REQ(2), .DATA_W(32)) bus ();

    bmu_arbiter #(.NUM_REQ(2), .DATA_W(32), .BMU_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // One-cycle BMU: add / arithmetic shift right; sra flags an error; idle output is garbage.
    always @(posedge clk) begin
        m_res <= !bus.bmuValidIn ? 32'hDEAD_BEEF :
                 bus.bmuAp.sra   ? 32'($signed(bus.bmuAIn) >>> bus.bmuBIn[4:0]) :
                 bus.bmuAp.add   ? bus.bmuAIn + bus.bmuBIn : bus.bmuAIn;
        m_err <= bus.bmuValidIn && bus.bmuAp.sra;
    end
    assign bus.bmuResultFf = m_res;
    assign bus.bmuError    = m_err | force_err;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        ap_add = '0; ap_add.add = 1'b1;
        ap_sra = '0; ap_sra.sra = 1'b1;
        force_err = 1'b0;
        rst = 1'b1;
        bus.reqValid = '0; bus.reqAp = '0; bus.reqA = '0; bus.reqB = '0;
        bus.reqCsrRen = '0; bus.reqCsrRdata = '0; bus.rspReady = '1;
        step(); step();
        bus.reqValid = 2'b11; #1;
        chk("rst_req_ready", bus.reqReady, 0);
        chk("rst_rsp_valid", bus.rspValid, 0);
        chk("rst_rsp_result", bus.rspResult, 0);
        chk("rst_rsp_error", bus.rspError, 0);
        chk("rst_bmu_valid", bus.bmuValidIn, 0);
        chk("rst_bmu_ap", bus.bmuAp, 0);
        bus.reqValid = '0;
        // single request: add 5+7
        step(); rst = 1'b0;
        bus.reqValid = 2'b01; bus.reqAp[0] = ap_add; bus.reqA[0] = 5; bus.reqB[0] = 7;
        bus.reqCsrRen[0] = 1'b1; bus.reqCsrRdata[0] = 32'h55; #1;
        chk("t1_ready", bus.reqReady, 2'b01);
        step(); bus.reqValid = '0; #1;
        chk("t1_bmu_valid", bus.bmuValidIn, 1);
        chk("t1_bmu_ap", bus.bmuAp, ap_add);
        chk("t1_bmu_a", bus.bmuAIn, 5);
        chk("t1_bmu_b", bus.bmuBIn, 7);
        chk("t1_csr_ren", bus.bmuCsrRenIn, 1);
        chk("t1_csr_rdata", bus.bmuCsrRdataIn, 32'h55);
        step();
        chk("t1_bmu_idle", bus.bmuValidIn, 0);
        chk("t1_ap_zero", bus.bmuAp, 0);
        chk("t1_a_hold", bus.bmuAIn, 5);
        chk("t1_no_rsp_yet", bus.rspValid, 0);
        step();
        chk("t1_rsp_valid", bus.rspValid, 2'b01);
        chk("t1_rsp_result", bus.rspResult[0], 12);
        chk("t1_rsp_error", bus.rspError, 0);
        step();
        chk("t1_drained", bus.rspValid, 0);
        // contention from reset
        rst = 1'b1; step(); rst = 1'b0;
        bus.reqValid = 2'b11; bus.reqAp[0] = ap_add; bus.reqAp[1] = ap_add;
        bus.reqA[0] = 1; bus.reqB[0] = 2; bus.reqA[1] = 10; bus.reqB[1] = 20; #1;
        chk("t2_c0_grant", bus.reqReady, 2'b01);
        step();
        chk("t2_c1_grant", bus.reqReady, 2'b10);
        chk("t2_c1_bmu_a", bus.bmuAIn, 1);
        step();
        chk("t2_c2_grant", bus.reqReady, 2'b00);
        chk("t2_c2_bmu_valid", bus.bmuValidIn, 1);
        chk("t2_c2_bmu_a", bus.bmuAIn, 10);
        step();
        chk("t2_c3_grant", bus.reqReady, 2'b01);
        chk("t2_c3_rsp_valid", bus.rspValid, 2'b01);
        chk("t2_c3_result0", bus.rspResult[0], 3);
        step();
        chk("t2_c4_grant", bus.reqReady, 2'b10);
        chk("t2_c4_rsp_valid", bus.rspValid, 2'b10);
        chk("t2_c4_result1", bus.rspResult[1], 30);
        chk("t2_c4_bmu_valid", bus.bmuValidIn, 1);
        bus.reqValid = '0;
        // backpressure on requester 1
        rst = 1'b1; step(); rst = 1'b0;
        bus.rspReady = 2'b01; bus.reqValid = 2'b10; bus.reqA[1] = 100; bus.reqB[1] = 1; #1;
        chk("t3_d0_grant", bus.reqReady, 2'b10);
        step();
        bus.reqValid = 2'b11; bus.reqA[0] = 2; bus.reqB[0] = 3; #1;
        chk("t3_d1_grant", bus.reqReady, 2'b01);
        step();
        chk("t3_d2_grant", bus.reqReady, 2'b00);
        step();
        chk("t3_d3_rsp_valid", bus.rspValid, 2'b10);
        chk("t3_d3_result1", bus.rspResult[1], 101);
        chk("t3_d3_grant", bus.reqReady, 2'b00);
        step();
        chk("t3_d4_rsp_valid", bus.rspValid, 2'b11);
        chk("t3_d4_result0", bus.rspResult[0], 5);
        chk("t3_req0_continues", bus.reqReady, 2'b01);
        step();
        bus.reqValid = 2'b10; bus.reqA[1] = 50; #1;
        chk("t3_still_blocked", bus.reqReady, 2'b00);
        bus.rspReady = 2'b11; #1;
        chk("t3_drain_grant", bus.reqReady, 2'b10);
        step();
        bus.reqValid = '0; #1;
        chk("t3_bmu_valid", bus.bmuValidIn, 1);
        chk("t3_bmu_a", bus.bmuAIn, 50);
        // error passthrough; slot 0 held
        rst = 1'b1; step(); rst = 1'b0;
        bus.rspReady = 2'b00; bus.reqValid = 2'b01; bus.reqA[0] = 20; bus.reqB[0] = 22; #1;
        chk("t4_e0_grant", bus.reqReady, 2'b01);
        step();
        bus.reqValid = 2'b10; bus.reqAp[1] = ap_sra; bus.reqA[1] = 32'hFFFF_FF00; bus.reqB[1] = 4; #1;
        chk("t4_e1_grant", bus.reqReady, 2'b10);
        step();
        bus.reqValid = '0;
        step();
        chk("t4_e3_rsp_valid", bus.rspValid, 2'b01);
        chk("t4_e3_result0", bus.rspResult[0], 42);
        step();
        chk("t4_e4_rsp_valid", bus.rspValid, 2'b11);
        chk("t4_e4_result1", bus.rspResult[1], 32'hFFFF_FFF0);
        chk("t4_e4_error", bus.rspError, 2'b10);
        chk("t4_e4_result0_kept", bus.rspResult[0], 42);
        force_err = 1'b1;
        step();
        force_err = 1'b0; #1;
        chk("t4_stray_err_ignored", bus.rspError, 2'b10);
        chk("t4_slots_held", bus.rspValid, 2'b11);
        // reset while the op is at the BMU
        rst = 1'b1; step(); rst = 1'b0;
        bus.rspReady = 2'b11; bus.reqValid = 2'b01; bus.reqAp[0] = ap_add; bus.reqA[0] = 1; bus.reqB[0] = 1; #1;
        chk("t5_f0_grant", bus.reqReady, 2'b01);
        step();
        bus.reqValid = '0; #1;
        chk("t5_f1_bmu_valid", bus.bmuValidIn, 1);
        rst = 1'b1;
        step();
        rst = 1'b0; #1;
        chk("t5_f2_bmu_valid", bus.bmuValidIn, 0);
        chk("t5_f2_bmu_a", bus.bmuAIn, 0);
        chk("t5_f2_bmu_ap", bus.bmuAp, 0);
        chk("t5_f2_rsp_valid", bus.rspValid, 0);
        step();
        chk("t5_f3_rsp_valid", bus.rspValid, 0);
        step();
        bus.reqValid = 2'b11; #1;
        chk("t5_f4_rsp_valid", bus.rspValid, 0);
        chk("t5_f4_ptr_reset", bus.reqReady, 2'b01);
        bus.reqValid = '0;
        // pointer wraps after serving requester 1 alone
        rst = 1'b1; step(); rst = 1'b0;
        bus.reqValid = 2'b10; #1;
        chk("t6_g0_grant", bus.reqReady, 2'b10);
        step();
        chk("t6_g1_grant", bus.reqReady, 2'b00);
        step();
        chk("t6_g2_grant", bus.reqReady, 2'b00);
        step();
        bus.reqValid = 2'b11; #1;
        chk("t6_g3_rsp_valid", bus.rspValid, 2'b10);
        chk("t6_g3_grant", bus.reqReady, 2'b01);
        bus.reqValid = '0;
        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
